// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: default widths,
// the hardwired $zero address and the packed-port slice helper.
package regfile_write_arbiter_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int ZERO_ADDR  = 0;

  // Low bit of lane idx in a port that packs equal-width lanes side by side.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// Per-core writeback buffer: synchronous FIFO with one push and one pop port,
// exposing occupancy, full/empty flags and the head entry.
module wb_fifo #(
  parameter int depth = 2,
  parameter int width = 37
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           push,
  input  logic                           pop,
  input  logic [width-1:0]               din,
  output logic [width-1:0]               head,
  output logic [$clog2(depth+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int PTR_W = $clog2(depth);
  localparam int CNT_W = $clog2(depth + 1);

  logic [width-1:0] r_mem [depth];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CNT_W'(depth));
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign head      = r_mem[r_rd_ptr];
  assign count     = r_count;

  // NOTE: sequential state is updated only with <= so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Buffers per-core register writebacks and drains them round-robin onto the
// register file's single registered write port.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int cores  = 4,
  parameter int addr_w = ADDR_W_DEF,
  parameter int data_w = DATA_W_DEF,
  parameter int depth  = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [cores-1:0]         core_wr_valid,
  output logic [cores-1:0]         core_wr_ready,
  input  logic [cores*addr_w-1:0]  core_wr_addr,
  input  logic [cores*data_w-1:0]  core_wr_data,
  output logic                     rf_we,
  output logic [addr_w-1:0]        rf_waddr,
  output logic [data_w-1:0]        rf_wdata,
  output logic                     idle
);

  localparam int ENT_W = addr_w + data_w;
  localparam int PTR_W = (cores > 1) ? $clog2(cores) : 1;
  localparam int CNT_W = $clog2(depth + 1);

  logic [cores-1:0] w_push;
  logic [cores-1:0] w_pop;
  logic [cores-1:0] w_full;
  logic [cores-1:0] w_empty;
  logic [ENT_W-1:0] w_head  [cores];
  logic [CNT_W-1:0] w_count [cores];

  logic             w_grant_vld;
  logic [PTR_W-1:0] w_grant_idx;
  logic [ENT_W-1:0] w_grant_head;
  logic             w_pending;

  logic [PTR_W-1:0]  r_ptr;
  logic              r_we;
  logic [addr_w-1:0] r_waddr;
  logic [data_w-1:0] r_wdata;

  function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base, input int off);
    return PTR_W'((int'(base) + off) % cores);
  endfunction

  for (genvar gi = 0; gi < cores; gi++) begin : g_core
    logic [addr_w-1:0] w_addr;
    logic [data_w-1:0] w_data;

    assign w_addr = core_wr_addr[slice_lo(gi, addr_w) +: addr_w];
    assign w_data = core_wr_data[slice_lo(gi, data_w) +: data_w];

    // Ready comes from state only; writes to $zero are accepted but dropped.
    assign core_wr_ready[gi] = !w_full[gi];
    assign w_push[gi] = core_wr_valid[gi] && !w_full[gi] && (w_addr != addr_w'(ZERO_ADDR));

    wb_fifo #(
      .depth (depth),
      .width (ENT_W)
    ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (w_push[gi]),
      .pop     (w_pop[gi]),
      .din     ({w_addr, w_data}),
      .head    (w_head[gi]),
      .count   (w_count[gi]),
      .full    (w_full[gi]),
      .empty   (w_empty[gi])
    );
  end

  // Scan from the farthest offset back to the pointer so the closest
  // non-empty buffer (in wrap-around order) is the last assignment and wins.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int off = cores - 1; off >= 0; off--) begin
      if (!w_empty[rr_index(r_ptr, off)]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = rr_index(r_ptr, off);
      end
    end
    w_pop = '0;
    if (w_grant_vld) w_pop[w_grant_idx] = 1'b1;
  end

  assign w_grant_head = w_head[w_grant_idx];

  always_comb begin
    w_pending = 1'b0;
    for (int i = 0; i < cores; i++) begin
      if (w_count[i] != '0) w_pending = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ptr   <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_grant_vld;
      if (w_grant_vld) begin
        r_waddr <= w_grant_head[ENT_W-1 -: addr_w];
        r_wdata <= w_grant_head[data_w-1:0];
        r_ptr   <= rr_index(w_grant_idx, 1);
      end
    end
  end

  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign idle     = !w_pending && !r_we;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (4 cores, depth 2),
// with a behavioural register file fed only by the DUT's write port.
module tb_regfile_write_arbiter;

  localparam int CORES  = 4;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic [CORES-1:0]        core_wr_valid;
  logic [CORES-1:0]        core_wr_ready;
  logic [CORES*ADDR_W-1:0] core_wr_addr;
  logic [CORES*DATA_W-1:0] core_wr_data;
  logic                    rf_we;
  logic [ADDR_W-1:0]       rf_waddr;
  logic [DATA_W-1:0]       rf_wdata;
  logic                    idle;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] rf_model [32];
  logic [ADDR_W-1:0] wr_log [$];

  regfile_write_arbiter #(
    .cores  (CORES),
    .addr_w (ADDR_W),
    .data_w (DATA_W),
    .depth  (2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .core_wr_valid (core_wr_valid),
    .core_wr_ready (core_wr_ready),
    .core_wr_addr  (core_wr_addr),
    .core_wr_data  (core_wr_data),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .idle          (idle)
  );

  always #5 clk = ~clk;

  // The register file itself: commits whatever the DUT drives at each edge.
  always @(posedge clk) begin
    if (rf_we) begin
      rf_model[rf_waddr] <= rf_wdata;
      wr_log.push_back(rf_waddr);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int i, input logic v, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
    core_wr_valid[i]                 = v;
    core_wr_addr[i*ADDR_W +: ADDR_W] = a;
    core_wr_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic clear_inputs();
    core_wr_valid = '0;
    core_wr_addr  = '0;
    core_wr_data  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [ADDR_W-1:0] exp_order [9];
    int n0;
    exp_order = '{5'd1, 5'd9, 5'd3, 5'd5, 5'd2, 5'd10, 5'd4, 5'd6, 5'd11};
    for (int r = 0; r < 32; r++) rf_model[r] = '0;

    // Reset state
    do_reset();
    check("rst_ready", 32'(core_wr_ready), 32'hF);
    check("rst_we",    32'(rf_we), 32'h0);
    check("rst_waddr", 32'(rf_waddr), 32'h0);
    check("rst_wdata", rf_wdata, 32'h0);
    check("rst_idle",  32'(idle), 32'h1);

    // 1: single write latency
    set_core(0, 1'b1, 5'd12, 32'd4);
    tick();                                   // edge N: accepted
    set_core(0, 1'b0, 5'd0, 32'd0);
    check("t1_we_n",    32'(rf_we), 32'h0);
    check("t1_idle_n",  32'(idle), 32'h0);
    tick();                                   // edge N+1: issued
    check("t1_we",      32'(rf_we), 32'h1);
    check("t1_waddr",   32'(rf_waddr), 32'd12);
    check("t1_wdata",   rf_wdata, 32'd4);
    check("t1_idle_n1", 32'(idle), 32'h0);
    tick();                                   // edge N+2: committed
    check("t1_we_off",  32'(rf_we), 32'h0);
    check("t1_idle",    32'(idle), 32'h1);
    check("t1_hold",    32'(rf_waddr), 32'd12);
    check("t1_rf12",    rf_model[12], 32'd4);

    // 2: four cores at one edge, pointer at 0
    do_reset();
    set_core(0, 1'b1, 5'd12, 32'd4);
    set_core(1, 1'b1, 5'd13, 32'd5);
    set_core(2, 1'b1, 5'd14, 32'd3);
    set_core(3, 1'b1, 5'd15, 32'd2);
    tick();
    clear_inputs();
    tick(); check("t2_a0", 32'(rf_waddr), 32'd12); check("t2_d0", rf_wdata, 32'd4); check("t2_we0", 32'(rf_we), 32'h1);
    tick(); check("t2_a1", 32'(rf_waddr), 32'd13); check("t2_d1", rf_wdata, 32'd5); check("t2_we1", 32'(rf_we), 32'h1);
    tick(); check("t2_a2", 32'(rf_waddr), 32'd14); check("t2_d2", rf_wdata, 32'd3); check("t2_we2", 32'(rf_we), 32'h1);
    tick(); check("t2_a3", 32'(rf_waddr), 32'd15); check("t2_d3", rf_wdata, 32'd2); check("t2_we3", 32'(rf_we), 32'h1);
    tick(); check("t2_we_off", 32'(rf_we), 32'h0);
    check("t2_rf12", rf_model[12], 32'd4);
    check("t2_rf13", rf_model[13], 32'd5);
    check("t2_rf14", rf_model[14], 32'd3);
    check("t2_rf15", rf_model[15], 32'd2);

    // 3: grant core 1 moves pointer to 2; then 3 beats 0
    set_core(1, 1'b1, 5'd20, 32'h20);
    tick();
    set_core(1, 1'b0, 5'd0, 32'd0);
    set_core(0, 1'b1, 5'd16, 32'h16);
    set_core(3, 1'b1, 5'd23, 32'h23);
    tick();
    clear_inputs();
    check("t3_first",  32'(rf_waddr), 32'd20);
    tick(); check("t3_core3", 32'(rf_waddr), 32'd23); check("t3_core3_d", rf_wdata, 32'h23);
    tick(); check("t3_core0", 32'(rf_waddr), 32'd16); check("t3_core0_d", rf_wdata, 32'h16);
    tick(); check("t3_we_off", 32'(rf_we), 32'h0);

    // 4: core 1 back-to-back while others are busy
    do_reset();
    wr_log.delete();
    set_core(0, 1'b1, 5'd1, 32'h101);
    set_core(1, 1'b1, 5'd9, 32'h109);
    set_core(2, 1'b1, 5'd3, 32'h103);
    set_core(3, 1'b1, 5'd5, 32'h105);
    tick();
    set_core(0, 1'b1, 5'd2,  32'h102);
    set_core(1, 1'b1, 5'd10, 32'h10A);
    set_core(2, 1'b1, 5'd4,  32'h104);
    set_core(3, 1'b1, 5'd6,  32'h106);
    check("t4_ready_1st", 32'(core_wr_ready), 32'hF);
    tick();
    clear_inputs();
    set_core(1, 1'b1, 5'd11, 32'h10B);
    check("t4_ready1_low", 32'(core_wr_ready[1]), 32'h0);
    tick();
    check("t4_ready1_back", 32'(core_wr_ready[1]), 32'h1);
    tick();
    clear_inputs();
    repeat (10) tick();
    check("t4_count", 32'(wr_log.size()), 32'd9);
    for (int i = 0; i < 9; i++) begin
      logic [ADDR_W-1:0] got;
      got = (i < wr_log.size()) ? wr_log[i] : 'x;
      check($sformatf("t4_order%0d", i), 32'(got), 32'(exp_order[i]));
    end
    check("t4_rf11", rf_model[11], 32'h10B);
    check("t4_idle", 32'(idle), 32'h1);

    // 5: write to $zero is swallowed
    n0 = wr_log.size();
    set_core(2, 1'b1, 5'd0, 32'd7);
    check("t5_ready_pre", 32'(core_wr_ready[2]), 32'h1);
    tick();
    clear_inputs();
    check("t5_ready", 32'(core_wr_ready), 32'hF);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t5_we%0d", i), 32'(rf_we), 32'h0);
      check($sformatf("t5_idle%0d", i), 32'(idle), 32'h1);
      tick();
    end
    check("t5_no_write", 32'(wr_log.size()), 32'(n0));

    // 6: reset while buffers are full discards everything
    for (int c = 0; c < CORES; c++) set_core(c, 1'b1, 5'(24 + c), 32'(16'hA0 + c));
    tick(); tick(); tick();
    check("t6_busy", 32'(idle), 32'h0);
    clear_inputs();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n0 = wr_log.size();
    check("t6_we",    32'(rf_we), 32'h0);
    check("t6_ready", 32'(core_wr_ready), 32'hF);
    check("t6_idle",  32'(idle), 32'h1);
    check("t6_waddr", 32'(rf_waddr), 32'h0);
    check("t6_wdata", rf_wdata, 32'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("t6_stale%0d", i), 32'(rf_we), 32'h0);
    end
    check("t6_no_write", 32'(wr_log.size()), 32'(n0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
